// File: rtl/pc_fetch_gen.sv
// Fetch-stage program-counter generator: holds the fetch PC, issues valid/ready requests,
// buffers one redirect/trap while a request waits, and halts on misaligned targets. Optional: RVC_EN.
module pc_fetch_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    output logic            fetch_valid,
    input  logic            fetch_ready,
    output logic [XLEN-1:0] fetch_pc,
    input  logic            fetch_rvc,
    output logic [XLEN-1:0] pc_plus,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_base,
    input  logic [XLEN-1:0] redir_offset,
    input  logic            redir_clr_lsb,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    output logic            misalign,
    output logic [XLEN-1:0] misalign_addr
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} FetchState;

    localparam logic [XLEN-1:0] INCR4 = XLEN'(4);

    FetchState       r_state;
    FetchState       w_stateNext;
    logic [XLEN-1:0] r_pc, w_pcNext;
    logic            r_valid, w_validNext;
    logic            r_pendValid, w_pendValidNext;
    logic            r_pendIsTrap, w_pendIsTrapNext;
    logic [XLEN-1:0] r_pendTarget, w_pendTargetNext;
    logic            r_misalign, w_misalignNext;
    logic [XLEN-1:0] r_misalignAddr, w_misalignAddrNext;

    logic [XLEN-1:0] w_incr, w_seqPc, w_redirSum, w_redirTarget, w_trapTarget, w_selTarget;
    logic            w_waiting, w_handshake, w_selValid, w_selIsRedir, w_selMisaligned;
    logic            w_unusedBits;

    assign w_waiting     = r_valid && !fetch_ready;
    assign w_handshake   = r_valid && fetch_ready;
    assign w_redirSum    = redir_base + redir_offset;
    assign w_redirTarget = {w_redirSum[XLEN-1:1], w_redirSum[0] & ~redir_clr_lsb};
    assign w_trapTarget  = {trap_vector[XLEN-1:2], 2'b00};

`ifdef RVC_EN
    assign w_incr          = fetch_rvc ? XLEN'(2) : INCR4;
    assign w_selMisaligned = w_selIsRedir && w_selTarget[0];
    assign w_unusedBits    = ^trap_vector[1:0];
`else
    assign w_incr          = INCR4;
    assign w_selMisaligned = w_selIsRedir && (w_selTarget[1:0] != 2'b00);
    assign w_unusedBits    = ^{trap_vector[1:0], fetch_rvc};
`endif

    assign w_seqPc = r_pc + w_incr;

    // Target priority: live trap, pending trap, live redirect (newest wins), pending redirect
    always_comb begin
        w_selValid   = 1'b0;
        w_selIsRedir = 1'b0;
        w_selTarget  = w_seqPc;
        if (trap_valid) begin
            w_selValid  = 1'b1;
            w_selTarget = w_trapTarget;
        end else if (r_pendValid && r_pendIsTrap) begin
            w_selValid  = 1'b1;
            w_selTarget = r_pendTarget;
        end else if (redir_valid) begin
            w_selValid   = 1'b1;
            w_selIsRedir = 1'b1;
            w_selTarget  = w_redirTarget;
        end else if (r_pendValid) begin
            w_selValid   = 1'b1;
            w_selIsRedir = 1'b1;
            w_selTarget  = r_pendTarget;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= BOOT;
        else       r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            BOOT:    w_stateNext = RUN;
            RUN:     if (!w_waiting && w_selValid && w_selMisaligned) w_stateNext = HALT;
            HALT:    if (trap_valid) w_stateNext = RUN;
            default: w_stateNext = BOOT;
        endcase
    end

    // Datapath updates; a waiting request freezes fetch_pc and only the pending entry moves
    always_comb begin
        w_pcNext           = r_pc;
        w_validNext        = r_valid;
        w_pendValidNext    = r_pendValid;
        w_pendIsTrapNext   = r_pendIsTrap;
        w_pendTargetNext   = r_pendTarget;
        w_misalignNext     = 1'b0;
        w_misalignAddrNext = r_misalignAddr;
        case (r_state)
            BOOT: begin
                w_validNext     = 1'b0;
                w_pendValidNext = 1'b0;
            end
            RUN: begin
                if (w_waiting) begin
                    if (trap_valid) begin
                        w_pendValidNext  = 1'b1;
                        w_pendIsTrapNext = 1'b1;
                        w_pendTargetNext = w_trapTarget;
                    end else if (redir_valid && !(r_pendValid && r_pendIsTrap)) begin
                        w_pendValidNext  = 1'b1;
                        w_pendIsTrapNext = 1'b0;
                        w_pendTargetNext = w_redirTarget;
                    end
                end else begin
                    w_pendValidNext = 1'b0;
                    if (w_selValid && w_selMisaligned) begin
                        w_validNext        = 1'b0;
                        w_misalignNext     = 1'b1;
                        w_misalignAddrNext = w_selTarget;
                    end else begin
                        if (w_selValid || w_handshake) w_pcNext = w_selTarget;
                        w_validNext = !stall;
                    end
                end
            end
            HALT: begin
                w_validNext     = 1'b0;
                w_pendValidNext = 1'b0;
                if (trap_valid) begin
                    w_pcNext    = w_trapTarget;
                    w_validNext = !stall;
                end
            end
            default: begin
                w_validNext     = 1'b0;
                w_pendValidNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc           <= RESET_VECTOR;
            r_valid        <= 1'b0;
            r_pendValid    <= 1'b0;
            r_pendIsTrap   <= 1'b0;
            r_pendTarget   <= '0;
            r_misalign     <= 1'b0;
            r_misalignAddr <= '0;
        end else begin
            r_pc           <= w_pcNext;
            r_valid        <= w_validNext;
            r_pendValid    <= w_pendValidNext;
            r_pendIsTrap   <= w_pendIsTrapNext;
            r_pendTarget   <= w_pendTargetNext;
            r_misalign     <= w_misalignNext;
            r_misalignAddr <= w_misalignAddrNext;
        end
    end

    assign fetch_valid   = r_valid;
    assign fetch_pc      = r_pc;
    assign pc_plus       = w_seqPc;
    assign misalign      = r_misalign;
    assign misalign_addr = r_misalignAddr;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Scoreboard bench for pc_fetch_gen: directed stimulus queues expected fetch PCs and
// misalign addresses; monitors pop and compare on every handshake / misalign pulse.
module tb_pc_fetch_gen;

    logic        clk = 1'b0;
    logic        reset, stall, fetch_ready, fetch_rvc;
    logic        redir_valid, redir_clr_lsb, trap_valid;
    logic [31:0] redir_base, redir_offset, trap_vector;
    logic        fetch_valid, misalign;
    logic [31:0] fetch_pc, pc_plus, misalign_addr;

    logic [31:0] pcQ[$];
    logic [31:0] misQ[$];
    logic [31:0] expPc, expMis, expIncr;
    int          errors = 0;
    int          checks = 0;

    pc_fetch_gen #(.XLEN(32), .RESET_VECTOR(32'h100)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .fetch_rvc(fetch_rvc), .pc_plus(pc_plus),
        .redir_valid(redir_valid), .redir_base(redir_base), .redir_offset(redir_offset),
        .redir_clr_lsb(redir_clr_lsb),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .misalign(misalign), .misalign_addr(misalign_addr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] base, input logic [31:0] off,
                                 input logic clr, input logic tv, input logic [31:0] vec);
        redir_valid   = rv;
        redir_base    = base;
        redir_offset  = off;
        redir_clr_lsb = clr;
        trap_valid    = tv;
        trap_vector   = vec;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Handshake and misalign monitors, sampled on the falling edge
    always @(negedge clk) begin
        if (!reset && fetch_valid && fetch_ready) begin
            if (pcQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedHandshake: got fetch_pc 0x%08h, expected no request", fetch_pc);
            end else begin
                expPc = pcQ.pop_front();
`ifdef RVC_EN
                expIncr = fetch_rvc ? 32'd2 : 32'd4;
`else
                expIncr = 32'd4;
`endif
                checkOutput("handshakePc", fetch_pc, expPc);
                checkOutput("pcPlus", pc_plus, expPc + expIncr);
            end
        end
        if (!reset && misalign) begin
            if (misQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedMisalign: got addr 0x%08h, expected no pulse", misalign_addr);
            end else begin
                expMis = misQ.pop_front();
                checkOutput("misalignAddr", misalign_addr, expMis);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; fetch_ready = 1'b1; fetch_rvc = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        #12;
        checkOutput("resetValid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("resetPc", fetch_pc, 32'h100);
        checkOutput("resetMisalign", {31'b0, misalign}, 32'h0);
        checkOutput("resetMisalignAddr", misalign_addr, 32'h0);

        // Boot then sequential stream 0x100, 0x104, 0x108
        @(posedge clk); #1;
        reset = 1'b0;
        pcQ.push_back(32'h100); pcQ.push_back(32'h104); pcQ.push_back(32'h108);
        tick(1);
        checkOutput("bootValid", {31'b0, fetch_valid}, 32'h0);
        tick(1);
        checkOutput("firstPc", fetch_pc, 32'h100);
        tick(2);
        stall = 1'b1;
        tick(1);
        checkOutput("stallDropsValid", {31'b0, fetch_valid}, 32'h0);

        // Request at 0x104 held for 3 cycles with a redirect buffered in the first
        fetch_ready = 1'b0; stall = 1'b0;
        applyStimulus(1'b1, 32'h100, 32'h4, 1'b0, 1'b0, 32'h0);
        pcQ.push_back(32'h104); pcQ.push_back(32'h124);
        tick(1);
        applyStimulus(1'b1, 32'h104, 32'h20, 1'b0, 1'b0, 32'h0);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("heldPc", fetch_pc, 32'h104);
        checkOutput("heldValid", {31'b0, fetch_valid}, 32'h1);
        tick(2);
        fetch_ready = 1'b1;
        tick(1);
        stall = 1'b1;
        tick(1);

        // Simultaneous trap and redirect: trap wins, vector low bits forced to 0
        stall = 1'b0;
        applyStimulus(1'b1, 32'h200, 32'h0, 1'b0, 1'b1, 32'h803);
        pcQ.push_back(32'h800);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        stall = 1'b1;
        tick(1);

        // Pending trap must not be overwritten by a later redirect
        fetch_ready = 1'b0; stall = 1'b0;
        applyStimulus(1'b1, 32'h300, 32'h0, 1'b0, 1'b0, 32'h0);
        pcQ.push_back(32'h300); pcQ.push_back(32'h500);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h500);
        tick(1);
        applyStimulus(1'b1, 32'h600, 32'h0, 1'b0, 1'b0, 32'h0);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        fetch_ready = 1'b1;
        tick(1);
        stall = 1'b1;
        tick(1);

`ifndef RVC_EN
        // Misaligned redirect halts; redirects ignored; trap resumes
        applyStimulus(1'b1, 32'h100, 32'h6, 1'b0, 1'b0, 32'h0);
        misQ.push_back(32'h106);
        tick(1);
        checkOutput("haltValid", {31'b0, fetch_valid}, 32'h0);
        checkOutput("haltPcHeld", fetch_pc, 32'h504);
        stall = 1'b0;
        applyStimulus(1'b1, 32'h700, 32'h0, 1'b0, 1'b0, 32'h0);
        tick(1);
        checkOutput("haltIgnoresRedir", {31'b0, fetch_valid}, 32'h0);
        checkOutput("misalignOnePulse", {31'b0, misalign}, 32'h0);
        checkOutput("misalignAddrHeld", misalign_addr, 32'h106);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h400);
        pcQ.push_back(32'h400);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        stall = 1'b1;
        tick(1);
`endif

        // fetch_rvc step, then JALR redirect in the handshake cycle
        stall = 1'b0; fetch_rvc = 1'b1;
        applyStimulus(1'b1, 32'h10, 32'h0, 1'b0, 1'b0, 32'h0);
        pcQ.push_back(32'h10);
`ifdef RVC_EN
        pcQ.push_back(32'h12);
`else
        pcQ.push_back(32'h14);
`endif
        pcQ.push_back(32'h30);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick(1);
        applyStimulus(1'b1, 32'h31, 32'h0, 1'b1, 1'b0, 32'h0);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        stall = 1'b1;
        tick(1);
        fetch_rvc = 1'b0;

        // Address wrap at the top of the space
        stall = 1'b0;
        applyStimulus(1'b1, 32'hFFFF_FFF0, 32'hC, 1'b0, 1'b0, 32'h0);
        pcQ.push_back(32'hFFFF_FFFC); pcQ.push_back(32'h0);
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick(1);
        stall = 1'b1;
        tick(1);
        checkOutput("wrapNextPc", fetch_pc, 32'h4);

        // Reset mid-stall with a pending redirect
        fetch_ready = 1'b0; stall = 1'b0;
        applyStimulus(1'b1, 32'h900, 32'h0, 1'b0, 1'b0, 32'h0);
        tick(1);
        applyStimulus(1'b1, 32'h950, 32'h0, 1'b0, 1'b0, 32'h0);
        stall = 1'b1;
        tick(1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
        reset = 1'b1;
        #2;
        checkOutput("asyncResetPc", fetch_pc, 32'h100);
        checkOutput("asyncResetValid", {31'b0, fetch_valid}, 32'h0);
        tick(1);
        reset = 1'b0; fetch_ready = 1'b1; stall = 1'b0;
        pcQ.push_back(32'h100); pcQ.push_back(32'h104);
        tick(3);
        stall = 1'b1;
        tick(2);

        checkOutput("pcQueueDrained", 32'(pcQ.size()), 32'h0);
        checkOutput("misQueueDrained", 32'(misQ.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised program-counter generator for the fetch stage, replacing the fixed 32-bit PC register and its PC+4 and branch-target adders.
- Holds the fetch PC.
- Issues fetch requests over a valid/ready handshake.
- Computes sequential and redirect targets internally.
- Buffers a redirect or trap that arrives while a request is waiting to be accepted.
- Detects misaligned targets.

It sits between the execute/trap logic and instruction memory.

## Interface
Parameters:
- XLEN, 32, address and data width.
- RESET_VECTOR, 0, fetch_pc value after reset.

Ports (reset is asynchronous, active-high; the clock is clk):
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- stall  in  1  suppress new fetch requests
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  instruction memory accepts the request
- fetch_pc  out  XLEN  address of the current request
- fetch_rvc  in  1  accepted instruction is 16-bit; sampled on handshake; ignored without RVC_EN
- pc_plus  out  XLEN  fetch_pc + instruction length (link value); combinational
- redir_valid  in  1  branch/jump redirect
- redir_base  in  XLEN  redirect base (PC or rs1)
- redir_offset  in  XLEN  redirect immediate
- redir_clr_lsb  in  1  clear bit 0 of the target (JALR)
- trap_valid  in  1  trap entry
- trap_vector  in  XLEN  trap target; bits [1:0] forced to 0
- misalign  out  1  one-cycle pulse, misaligned target
- misalign_addr  out  XLEN  offending target; holds until the next misalign

## Operation
Handshake and targets:
- A handshake occurs when fetch_valid && fetch_ready.
- fetch_pc is stable while fetch_valid && !fetch_ready.
- Sequential next PC = fetch_pc + 4, or + 2 when RVC_EN is defined and fetch_rvc is 1.
- Redirect target = (redir_base + redir_offset) mod 2^XLEN, then bit 0 is cleared if redir_clr_lsb.

Priority and pending register:
- Priority: trap > redirect > sequential. Simultaneous trap and redirect: the redirect is dropped.
- While a request is waiting (fetch_valid && !fetch_ready), a redirect or trap is stored in a one-entry pending register:
  - a trap overwrites a pending redirect;
  - a redirect never overwrites a pending trap;
  - a newer redirect overwrites an older pending redirect.
- On handshake, the next fetch_pc is the pending target if one is stored, otherwise the sequential PC. The pending register then clears.
- When fetch_valid is 0, a redirect or trap is applied directly on the next edge.

Valid generation:
- After a handshake, or while idle, fetch_valid_next = !stall.
- Once fetch_valid is asserted, it stays high until the handshake, regardless of stall.

State machine (states BOOT, RUN, HALT):
- BOOT: state on reset; fetch_valid 0. Moves to RUN after one cycle.
- RUN: normal fetch.
- HALT: entered when a misaligned redirect target is applied. misalign pulses and misalign_addr takes the target. fetch_valid is 0 and fetch_pc is unchanged. Redirects are ignored. Only trap_valid leaves HALT, moving to RUN at the trap vector.

Misalignment rule:
- With RVC_EN: bit 0 set.
- Without RVC_EN: bits [1:0] not both 0.

## Timing
- Reset values: state BOOT, fetch_pc RESET_VECTOR, fetch_valid 0, misalign 0, misalign_addr 0, pending register empty.
- Reset is asynchronous and acts immediately, mid-request or with a pending entry included. There is no handshake in the reset cycle.
- The first request appears 2 edges after reset deasserts (BOOT, then RUN), if stall is 0.
- Throughput: one request per cycle while fetch_ready = 1 and stall = 0.
- Redirect with no outstanding request: fetch_pc = target and fetch_valid = !stall at the next edge.
- Redirect in the handshake cycle: it takes effect at that same edge; the sequential PC is discarded.
- Stall: fetch_valid drops one cycle after stall rises, unless a request is outstanding.
- Address wrap: 0xFFFF_FFFC + 4 = 0x0000_0000, with no flag.
- misalign is asserted in the cycle after the target is applied.

## Configuration
- RVC_EN defined: 16-bit instruction support, with +2 sequencing, 2-byte target alignment and fetch_rvc honoured.
- RVC_EN undefined: always +4; fetch_rvc ignored; 4-byte alignment required.

## Test plan
- Reset with RESET_VECTOR=0x100 and fetch_ready=1 -> fetch_valid 0 for 1 cycle after deassert, then fetch_pc 0x100, 0x104, 0x108, one per cycle.
- fetch_ready held 0 for 3 cycles at 0x104, with a redirect base 0x104 offset 0x20 in cycle 1 -> fetch_pc stays 0x104; after the handshake, fetch_pc is 0x124.
- Simultaneous trap_vector 0x803 and redirect to 0x200 -> next fetch_pc 0x800.
- No RVC_EN, redirect base 0x100 offset 0x6 -> misalign pulses once with misalign_addr 0x106. Then trap to 0x400 -> fetch resumes at 0x400.
- RVC_EN with fetch_rvc=1 at 0x10 -> next fetch_pc 0x12. JALR base 0x31, clr_lsb=1 -> 0x30, no misalign.
- fetch_pc 0xFFFF_FFFC, handshake -> fetch_pc 0x0. Assert reset mid-stall with a pending redirect -> fetch_pc RESET_VECTOR, pending register empty.
